// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types and default widths for the branch resolve unit
package bru_pkg;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic              v;
    logic              br;
    logic [ADDR_W-1:0] tgt;
  } bru_entry_t;
endpackage

// File: rtl/bru_stage_reg.sv
// rtl/bru_stage_reg.sv - one pipe entry {v, br, tgt} with hold-enable and sync clear
module bru_stage_reg #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_v,
  input  logic              i_br,
  input  logic [ADDR_W-1:0] i_tgt,
  output logic              o_v,
  output logic              o_br,
  output logic [ADDR_W-1:0] o_tgt
);
  logic              r_v;
  logic              r_br;
  logic [ADDR_W-1:0] r_tgt;

  // Clear wins over load so a squash edge never lets a wrong-path bundle in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v   <= 1'b0;
      r_br  <= 1'b0;
      r_tgt <= '0;
    end else if (i_clr) begin
      r_v   <= 1'b0;
      r_br  <= 1'b0;
      r_tgt <= '0;
    end else if (i_en) begin
      r_v   <= i_v;
      r_br  <= i_br;
      r_tgt <= i_tgt;
    end
  end

  assign o_v   = r_v;
  assign o_br  = r_br;
  assign o_tgt = r_tgt;
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves EX branches, redirects fetch and squashes wrong-path bundles
module branch_resolve_unit #(
  parameter int ADDR_W = bru_pkg::ADDR_W,
  parameter int CNT_W  = bru_pkg::CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_if_valid,
  input  logic              i_if_is_branch,
  input  logic [ADDR_W-1:0] i_if_target,
  input  logic              i_ex_taken,
  output logic              o_correct_en,
  output logic [ADDR_W-1:0] o_correction,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_br_count,
  output logic [CNT_W-1:0]  o_mp_count
);
  import bru_pkg::*;

  bru_state_e        r_state;
  bru_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_correction;
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_mp_count;

  logic              w_advance;
  logic              w_resolve;
  logic              w_mispredict;
  logic              w_squash;
  logic              w_id_v;
  logic              w_id_br;
  logic [ADDR_W-1:0] w_id_tgt;
  logic              w_ex_v;
  logic              w_ex_br;
  logic [ADDR_W-1:0] w_ex_tgt;

  assign w_advance    = !i_hold;
  assign w_resolve    = (r_state == RUN) && w_advance && w_ex_v && w_ex_br;
  assign w_mispredict = w_resolve && i_ex_taken;
  // Both the mispredict edge and the redirect exit edge drop whatever fetch handed us.
  assign w_squash     = w_mispredict || ((r_state == REDIRECT) && w_advance);

  bru_stage_reg #(.ADDR_W(ADDR_W)) u_id (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_advance),
    .i_clr (w_squash),
    .i_v   (i_if_valid),
    .i_br  (i_if_is_branch),
    .i_tgt (i_if_target),
    .o_v   (w_id_v),
    .o_br  (w_id_br),
    .o_tgt (w_id_tgt)
  );

  bru_stage_reg #(.ADDR_W(ADDR_W)) u_ex (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_advance),
    .i_clr (w_squash),
    .i_v   (w_id_v),
    .i_br  (w_id_br),
    .i_tgt (w_id_tgt),
    .o_v   (w_ex_v),
    .o_br  (w_ex_br),
    .o_tgt (w_ex_tgt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_mispredict) w_state_nxt = REDIRECT;
      REDIRECT: if (w_advance)    w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_correct_en = 1'b0;
    o_flush      = 1'b0;
    if (r_state == REDIRECT) begin
      o_correct_en = 1'b1;
      o_flush      = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_correction <= '0;
    end else if (w_mispredict) begin
      r_correction <= w_ex_tgt;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else begin
      if (w_resolve && (r_br_count != {CNT_W{1'b1}})) begin
        r_br_count <= r_br_count + CNT_W'(1);
      end
      if (w_mispredict && (r_mp_count != {CNT_W{1'b1}})) begin
        r_mp_count <= r_mp_count + CNT_W'(1);
      end
    end
  end

  assign o_correction = r_correction;
  assign o_br_count   = r_br_count;
  assign o_mp_count   = r_mp_count;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed-vector bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic        clk;
  logic        rst;
  logic        hold;
  logic        if_valid;
  logic        if_is_branch;
  logic [9:0]  if_target;
  logic        ex_taken;
  logic        correct_en;
  logic [9:0]  correction;
  logic        flush;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  logic        b_hold;
  logic        b_if_valid;
  logic        b_if_is_branch;
  logic [9:0]  b_if_target;
  logic        b_ex_taken;
  logic        b_correct_en;
  logic [9:0]  b_correction;
  logic        b_flush;
  logic [3:0]  b_br_count;
  logic [3:0]  b_mp_count;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_hold         (hold),
    .i_if_valid     (if_valid),
    .i_if_is_branch (if_is_branch),
    .i_if_target    (if_target),
    .i_ex_taken     (ex_taken),
    .o_correct_en   (correct_en),
    .o_correction   (correction),
    .o_flush        (flush),
    .o_br_count     (br_count),
    .o_mp_count     (mp_count)
  );

  branch_resolve_unit #(.ADDR_W(10), .CNT_W(4)) dut_sat (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_hold         (b_hold),
    .i_if_valid     (b_if_valid),
    .i_if_is_branch (b_if_is_branch),
    .i_if_target    (b_if_target),
    .i_ex_taken     (b_ex_taken),
    .o_correct_en   (b_correct_en),
    .o_correction   (b_correction),
    .o_flush        (b_flush),
    .o_br_count     (b_br_count),
    .o_mp_count     (b_mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0; if_valid = 1'b0; if_is_branch = 1'b0; if_target = '0; ex_taken = 1'b0;
    b_hold = 1'b0; b_if_valid = 1'b0; b_if_is_branch = 1'b0; b_if_target = '0; b_ex_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Branch at IF now; returns one cycle after its EX cycle (the would-be redirect cycle).
  task automatic run_branch(input logic [9:0] tgt, input logic taken);
    if_valid = 1'b1; if_is_branch = 1'b1; if_target = tgt;
    cyc();
    if_valid = 1'b0; if_is_branch = 1'b0;
    cyc();
    ex_taken = taken;
    cyc();
    ex_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL reset_correct_en got=%b exp=0", correct_en); n_err++; end
    n_vec++; if (flush !== 1'b0) begin $display("FAIL reset_flush got=%b exp=0", flush); n_err++; end
    n_vec++; if (correction !== 10'h000) begin $display("FAIL reset_correction got=%h exp=000", correction); n_err++; end
    n_vec++; if (br_count !== 16'h0) begin $display("FAIL reset_br_count got=%h exp=0", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'h0) begin $display("FAIL reset_mp_count got=%h exp=0", mp_count); n_err++; end
  endtask

  task automatic test_not_taken();
    int seen;
    do_reset();
    seen = 0;
    run_branch(10'h1A4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (correct_en) seen++;
      cyc();
    end
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL nt_br_count got=%0d exp=1", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd0) begin $display("FAIL nt_mp_count got=%0d exp=0", mp_count); n_err++; end
    n_vec++; if (seen !== 0) begin $display("FAIL nt_correct_en cycles_high=%0d exp=0", seen); n_err++; end
    n_vec++; if (correction !== 10'h000) begin $display("FAIL nt_correction got=%h exp=000", correction); n_err++; end
  endtask

  task automatic test_taken();
    do_reset();
    run_branch(10'h1A4, 1'b1);
    n_vec++; if (correct_en !== 1'b1) begin $display("FAIL tk_correct_en got=%b exp=1", correct_en); n_err++; end
    n_vec++; if (flush !== 1'b1) begin $display("FAIL tk_flush got=%b exp=1", flush); n_err++; end
    n_vec++; if (correction !== 10'h1A4) begin $display("FAIL tk_correction got=%h exp=1a4", correction); n_err++; end
    n_vec++; if (mp_count !== 16'd1) begin $display("FAIL tk_mp_count got=%0d exp=1", mp_count); n_err++; end
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL tk_br_count got=%0d exp=1", br_count); n_err++; end
    cyc();
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL tk_correct_en_drop got=%b exp=0", correct_en); n_err++; end
    n_vec++; if (flush !== 1'b0) begin $display("FAIL tk_flush_drop got=%b exp=0", flush); n_err++; end
    n_vec++; if (correction !== 10'h1A4) begin $display("FAIL tk_correction_keep got=%h exp=1a4", correction); n_err++; end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    run_branch(10'h1A4, 1'b1);
    hold = 1'b1; ex_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (correct_en !== 1'b1) begin $display("FAIL hold_correct_en cyc=%0d got=%b exp=1", i, correct_en); n_err++; end
      n_vec++; if (correction !== 10'h1A4) begin $display("FAIL hold_correction cyc=%0d got=%h exp=1a4", i, correction); n_err++; end
      cyc();
    end
    hold = 1'b0; ex_taken = 1'b0;
    n_vec++; if (correct_en !== 1'b1) begin $display("FAIL hold_correct_en cyc=3 got=%b exp=1", correct_en); n_err++; end
    n_vec++; if (correction !== 10'h1A4) begin $display("FAIL hold_correction cyc=3 got=%h exp=1a4", correction); n_err++; end
    cyc();
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL hold_release got=%b exp=0", correct_en); n_err++; end
    n_vec++; if (mp_count !== 16'd1) begin $display("FAIL hold_mp_count got=%0d exp=1", mp_count); n_err++; end
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL hold_br_count got=%0d exp=1", br_count); n_err++; end
  endtask

  task automatic test_back_to_back();
    int redirects;
    do_reset();
    redirects = 0;
    if_valid = 1'b1; if_is_branch = 1'b1; if_target = 10'h1A4;
    cyc();
    if_target = 10'h2B8;
    cyc();
    ex_taken = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      if (correct_en) redirects++;
      if (i == 1) if_valid = 1'b0;
      cyc();
    end
    ex_taken = 1'b0; if_is_branch = 1'b0;
    n_vec++; if (redirects !== 1) begin $display("FAIL b2b_redirects got=%0d exp=1", redirects); n_err++; end
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL b2b_br_count got=%0d exp=1", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd1) begin $display("FAIL b2b_mp_count got=%0d exp=1", mp_count); n_err++; end
    n_vec++; if (correction !== 10'h1A4) begin $display("FAIL b2b_correction got=%h exp=1a4", correction); n_err++; end
  endtask

  task automatic test_hold_run();
    do_reset();
    if_valid = 1'b1; if_is_branch = 1'b1; if_target = 10'h0F3;
    cyc();
    if_valid = 1'b0; if_is_branch = 1'b0;
    cyc();
    hold = 1'b1; ex_taken = 1'b1;
    cyc();
    cyc();
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL hrun_correct_en got=%b exp=0", correct_en); n_err++; end
    n_vec++; if (br_count !== 16'd0) begin $display("FAIL hrun_br_held got=%0d exp=0", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd0) begin $display("FAIL hrun_mp_held got=%0d exp=0", mp_count); n_err++; end
    hold = 1'b0; ex_taken = 1'b0;
    cyc();
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL hrun_br_count got=%0d exp=1", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd0) begin $display("FAIL hrun_mp_count got=%0d exp=0", mp_count); n_err++; end
  endtask

  task automatic test_resolve_with_if();
    do_reset();
    if_valid = 1'b1; if_is_branch = 1'b1; if_target = 10'h111;
    cyc();
    if_valid = 1'b0; if_is_branch = 1'b0;
    cyc();
    if_valid = 1'b1; if_is_branch = 1'b1; if_target = 10'h3C5;
    cyc();
    if_valid = 1'b0; if_is_branch = 1'b0;
    n_vec++; if (br_count !== 16'd1) begin $display("FAIL rwi_first_br got=%0d exp=1", br_count); n_err++; end
    cyc();
    ex_taken = 1'b1;
    cyc();
    ex_taken = 1'b0;
    n_vec++; if (br_count !== 16'd2) begin $display("FAIL rwi_br_count got=%0d exp=2", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd1) begin $display("FAIL rwi_mp_count got=%0d exp=1", mp_count); n_err++; end
    n_vec++; if (correction !== 10'h3C5) begin $display("FAIL rwi_correction got=%h exp=3c5", correction); n_err++; end
    n_vec++; if (correct_en !== 1'b1) begin $display("FAIL rwi_correct_en got=%b exp=1", correct_en); n_err++; end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    run_branch(10'h1A4, 1'b1);
    n_vec++; if (correct_en !== 1'b1) begin $display("FAIL arst_pre_correct_en got=%b exp=1", correct_en); n_err++; end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL arst_correct_en got=%b exp=0", correct_en); n_err++; end
    n_vec++; if (flush !== 1'b0) begin $display("FAIL arst_flush got=%b exp=0", flush); n_err++; end
    n_vec++; if (br_count !== 16'd0) begin $display("FAIL arst_br_count got=%0d exp=0", br_count); n_err++; end
    n_vec++; if (mp_count !== 16'd0) begin $display("FAIL arst_mp_count got=%0d exp=0", mp_count); n_err++; end
    n_vec++; if (correction !== 10'h000) begin $display("FAIL arst_correction got=%h exp=000", correction); n_err++; end
    cyc();
    rst = 1'b0;
    cyc();
    n_vec++; if (correct_en !== 1'b0) begin $display("FAIL arst_after got=%b exp=0", correct_en); n_err++; end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_cnt;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      b_if_valid = 1'b1; b_if_is_branch = 1'b1; b_if_target = 10'(n);
      cyc();
      b_if_valid = 1'b0; b_if_is_branch = 1'b0;
      cyc();
      b_ex_taken = 1'b1;
      cyc();
      b_ex_taken = 1'b0;
      exp_cnt = (n >= 15) ? 4'hF : 4'(n);
      n_vec++; if (b_br_count !== exp_cnt) begin $display("FAIL sat_br_count n=%0d got=%h exp=%h", n, b_br_count, exp_cnt); n_err++; end
      n_vec++; if (b_mp_count !== exp_cnt) begin $display("FAIL sat_mp_count n=%0d got=%h exp=%h", n, b_mp_count, exp_cnt); n_err++; end
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0; if_valid = 1'b0; if_is_branch = 1'b0; if_target = '0; ex_taken = 1'b0;
    b_hold = 1'b0; b_if_valid = 1'b0; b_if_is_branch = 1'b0; b_if_target = '0; b_ex_taken = 1'b0;
    test_reset();
    test_not_taken();
    test_taken();
    test_hold_redirect();
    test_back_to_back();
    test_hold_run();
    test_resolve_with_if();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
